// File: rtl/mem_access_unit.sv
// Load/store front end: turns byte/half/word requests into word-wide dmemory commands.
// Define LSU_BIG_ENDIAN_EN for big-endian byte/half lane numbering.
module mem_access_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] read_address,
  output logic [WIDTH-1:0] write_address,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] mem_data
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DepthW = WIDTH'(DEPTH);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StMrg, StCap, StResp} state_e;

  state_e           state_q;
  logic             write_q, signed_q, err_q;
  logic [1:0]       size_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;

  logic             accept, req_err;
  logic [1:0]       byte_lane;
  logic             half_lane;
  logic [ShW-1:0]   byte_shift, half_shift;
  logic [7:0]       mem_byte;
  logic [15:0]      mem_half;
  logic [WIDTH-1:0] load_data, merge_data, word_idx;

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[WIDTH-1:2]} >= DepthW) req_err = 1'b1;
  end

`ifdef LSU_BIG_ENDIAN_EN
  assign byte_lane = ~addr_q[1:0];
  assign half_lane = ~addr_q[1];
`else
  assign byte_lane = addr_q[1:0];
  assign half_lane = addr_q[1];
`endif

  assign byte_shift = ShW'({byte_lane, 3'b000});
  assign half_shift = ShW'({half_lane, 4'b0000});
  assign mem_byte   = mem_data[byte_shift +: 8];
  assign mem_half   = mem_data[half_shift +: 16];

  always_comb begin
    load_data  = mem_data;
    merge_data = mem_data;
    unique case (size_q)
      2'b00: begin
        load_data  = {{(WIDTH-8){signed_q & mem_byte[7]}}, mem_byte};
        merge_data = (mem_data & ~({{(WIDTH-8){1'b0}}, 8'hFF} << byte_shift))
                   | ({{(WIDTH-8){1'b0}}, wdata_q[7:0]} << byte_shift);
      end
      2'b01: begin
        load_data  = {{(WIDTH-16){signed_q & mem_half[15]}}, mem_half};
        merge_data = (mem_data & ~({{(WIDTH-16){1'b0}}, 16'hFFFF} << half_shift))
                   | ({{(WIDTH-16){1'b0}}, wdata_q[15:0]} << half_shift);
      end
      default: begin
        load_data  = mem_data;
        merge_data = mem_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_err;
            if (req_err)                           state_q <= StResp;
            else if (req_write && req_size == 2'b10) state_q <= StWr;
            else                                   state_q <= StRd;
          end
        end
        StWr:  state_q <= StResp;
        StRd:  state_q <= write_q ? StMrg : StCap;
        StMrg: state_q <= StResp;
        StCap: begin
          rdata_q <= load_data;
          state_q <= StResp;
        end
        StResp: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Commands are gated by reset so an RMW aborted in MRG never writes.
  assign word_idx      = {2'b00, addr_q[WIDTH-1:2]};
  assign mem_read      = (state_q == StRd) && !reset;
  assign mem_write     = ((state_q == StWr) || (state_q == StMrg)) && !reset;
  assign read_address  = mem_read  ? word_idx : '0;
  assign write_address = mem_write ? word_idx : '0;
  assign write_data    = mem_write ? ((state_q == StMrg) ? merge_data : wdata_q) : '0;

  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural dmemory model.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, read_address, write_address, write_data, mem_data;

  mem_access_unit #(.WIDTH(32), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .read_address(read_address), .write_address(write_address),
    .write_data(write_data), .mem_data(mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem_model [1024];
  initial mem_data = '0;
  always @(posedge clk) begin
    if (mem_write) mem_model[write_address[9:0]] <= write_data;
    if (mem_read)  mem_data <= mem_model[read_address[9:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef LSU_BIG_ENDIAN_EN
  localparam logic [31:0] ExpLb13 = 32'h0000_0001, ExpLbu12 = 32'h0000_007F;
  localparam logic [31:0] ExpLh10 = 32'hFFFF_80FF, ExpLb10  = 32'hFFFF_FF80;
  localparam logic [31:0] ExpLhu12 = 32'h0000_7F01, ExpLh12 = 32'h0000_7F01;
  localparam logic [31:0] ExpSb11 = 32'h11AA_3344, ExpSh12  = 32'h11AA_BEEF;
`else
  localparam logic [31:0] ExpLb13 = 32'hFFFF_FF80, ExpLbu12 = 32'h0000_00FF;
  localparam logic [31:0] ExpLh10 = 32'h0000_7F01, ExpLb10  = 32'h0000_0001;
  localparam logic [31:0] ExpLhu12 = 32'h0000_80FF, ExpLh12 = 32'hFFFF_80FF;
  localparam logic [31:0] ExpSb11 = 32'h1122_AA44, ExpSh12  = 32'hBEEF_AA44;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] idx;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_issued = 0;
  int   drv_timeouts = 0;
  logic stim_done = 1'b0;

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push, input exp_t e);
    bit got;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wdata;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      drv_timeouts++;
      return;
    end
    e.acc = cyc;
    if (push) sb_q.push_back(e);
    n_issued++;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                    input logic [31:0] exp_v);
    exp_t e;
    e.rdata = exp_v; e.err = 1'b0; e.lat = 3; e.nrd = 1; e.nwr = 0;
    e.idx = addr >> 2; e.wdata = '0; e.acc = 0;
    issue(1'b0, sz, sg, addr, 32'h0, 1'b1, e);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_word);
    exp_t e;
    e.rdata = '0; e.err = 1'b0;
    e.lat = (sz == 2'b10) ? 2 : 3;
    e.nrd = (sz == 2'b10) ? 0 : 1;
    e.nwr = 1;
    e.idx = addr >> 2; e.wdata = exp_word; e.acc = 0;
    issue(1'b1, sz, 1'b0, addr, wdata, 1'b1, e);
  endtask

  task automatic bad(input logic wr, input logic [1:0] sz, input logic [31:0] addr);
    exp_t e;
    e.rdata = '0; e.err = 1'b1; e.lat = 1; e.nrd = 0; e.nwr = 0;
    e.idx = '0; e.wdata = '0; e.acc = 0;
    issue(wr, sz, 1'b0, addr, 32'hFFFF_FFFF, 1'b1, e);
  endtask

  initial begin
    exp_t dummy;
    dummy.rdata = '0; dummy.err = 1'b0; dummy.lat = 0; dummy.nrd = 0; dummy.nwr = 0;
    dummy.idx = '0; dummy.wdata = '0; dummy.acc = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    st(2'b10, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ld(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    st(2'b10, 32'h10, 32'h80FF_7F01, 32'h80FF_7F01);
    ld(2'b00, 1'b1, 32'h13, ExpLb13);
    ld(2'b00, 1'b0, 32'h12, ExpLbu12);
    ld(2'b01, 1'b1, 32'h10, ExpLh10);
    ld(2'b00, 1'b1, 32'h10, ExpLb10);
    ld(2'b01, 1'b0, 32'h12, ExpLhu12);
    ld(2'b01, 1'b1, 32'h12, ExpLh12);
    st(2'b10, 32'h10, 32'h1122_3344, 32'h1122_3344);
    st(2'b00, 32'h11, 32'hFFFF_FFAA, ExpSb11);
    st(2'b01, 32'h12, 32'h1234_BEEF, ExpSh12);
    ld(2'b10, 1'b0, 32'h10, ExpSh12);

    bad(1'b0, 2'b01, 32'h11);
    bad(1'b0, 2'b10, 32'h12);
    bad(1'b1, 2'b10, 32'h12);
    bad(1'b0, 2'b11, 32'h10);
    bad(1'b0, 2'b10, 32'h1000);
    bad(1'b1, 2'b00, 32'h1003);
    st(2'b10, 32'hFFC, 32'hCAFE_F00D, 32'hCAFE_F00D);
    ld(2'b10, 1'b0, 32'hFFC, 32'hCAFE_F00D);
    ld(2'b10, 1'b0, 32'h10, ExpSh12);

    // Reset lands on the MRG cycle of an sb; the target word must survive.
    st(2'b10, 32'h14, 32'h1122_3344, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_0055, 1'b0, dummy);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ld(2'b10, 1'b0, 32'h14, 32'h1122_3344);

    // req_valid stays high across alternating stores and loads.
    for (int i = 0; i < 4; i++) begin
      st(2'b10, 32'h20 + 32'(4 * i), 32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(i));
      ld(2'b10, 1'b0, 32'h20 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    end
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    stim_done = 1'b1;
  end

  // ---------------- monitor ----------------
  int   nvec = 0, nfail = 0;
  int   rd_cnt = 0, wr_cnt = 0, acc_cnt = 0;
  logic both_seen = 1'b0, prev_reset = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_seen = 1'b1;
      if (reset) begin
        chk("reset_no_cmd", {30'b0, mem_read, mem_write}, 32'h0);
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (prev_reset) chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
        if (req_valid && req_ready) acc_cnt++;
        if (mem_read) begin
          rd_cnt++;
          if (sb_q.size() > 0) chk("read_address", read_address, sb_q[0].idx);
        end
        if (mem_write) begin
          wr_cnt++;
          if (sb_q.size() > 0) begin
            chk("write_address", write_address, sb_q[0].idx);
            chk("write_data", write_data, sb_q[0].wdata);
          end
        end
        if (resp_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_resp", 32'h1, 32'h0);
          end else begin
            e = sb_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("mem_reads", 32'(rd_cnt), 32'(e.nrd));
            chk("mem_writes", 32'(wr_cnt), 32'(e.nwr));
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
      prev_reset = reset;
      if (stim_done) break;
      if (cyc > 5000) begin
        chk("sim_timeout", 32'h1, 32'h0);
        break;
      end
    end
    chk("pending_responses", 32'(sb_q.size()), 32'h0);
    chk("read_write_overlap", {31'b0, both_seen}, 32'h0);
    chk("accept_count", 32'(acc_cnt), 32'(n_issued));
    chk("accept_timeouts", 32'(drv_timeouts), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
